traffic_phase_scheduler: RTL and testbench

//  Demand-driven phase scheduler for the four-approach junction (M1/M2 main, MT main-turn, S side, pedestrian).

---
 rtl/traffic_phase_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven four-phase junction scheduler: latches requests, rotates phases, times GREEN/YELLOW/ALLRED on tick.
// Define EMERG_PREEMPT_EN to add the emerg port and emergency preemption toward phase 0.
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] req,
`ifdef EMERG_PREEMPT_EN
    input  logic       emerg,
`endif
    output logic [3:0] grant,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       walk
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [CNT_W-1:0] T_MIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_MAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_RED = CNT_W'(ALLRED_T - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       pend_q, pend_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       cur_q, cur_d;
    logic [3:0]       grant_q, grant_d;
    logic [2:0]       m1_q, m1_d, m2_q, m2_d, mt_q, mt_d, s_q, s_d;
    logic             walk_q, walk_d;

    logic             emerg_i;
    logic [3:0]       cur_onehot, others, set, clr;
    logic [1:0]       next_ph, idx;
    logic             found, hold_main, green_exit;
    logic [2:0]       lamp_on;

`ifdef EMERG_PREEMPT_EN
    assign emerg_i = emerg;
`else
    assign emerg_i = 1'b0;
`endif

    // Timer stops at GREEN_MAX-1 so an indefinitely resting main green cannot wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= T_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cur_d      = cur_q;
        rr_ptr_d   = rr_ptr_q;
        set        = req;
        clr        = 4'b0000;
        cur_onehot = 4'b0001 << cur_q;
        others     = pend_q & ~cur_onehot;
        hold_main  = emerg_i && (cur_q == 2'd0);
        green_exit = 1'b0;

        // Round-robin search starts one past the last served phase; offset 4 wraps back to it.
        next_ph = 2'd0;
        found   = 1'b0;
        idx     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && pend_q[idx]) begin
                next_ph = idx;
                found   = 1'b1;
            end
        end
        if (emerg_i) begin
            next_ph = 2'd0;
        end

        case (state_q)
            ST_GREEN: begin
                green_exit = (emerg_i && (cur_q != 2'd0)) ||
                             (tick && (((timer_q >= T_MIN) && (|others) && !hold_main) ||
                                       ((cur_q != 2'd0) && (timer_q == T_MAX))));
                if (green_exit) begin
                    state_d = ST_YELLOW;
                    timer_d = '0;
                end else begin
                    set[cur_q] = 1'b0;
                    if (tick) begin
                        timer_d = sat_inc(timer_q);
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (timer_q == T_YEL) begin
                        state_d = ST_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = sat_inc(timer_q);
                    end
                end
            end
            ST_ALLRED: begin
                if (tick) begin
                    if (timer_q == T_RED) begin
                        state_d  = ST_GREEN;
                        timer_d  = '0;
                        cur_d    = next_ph;
                        rr_ptr_d = next_ph;
                        clr      = 4'b0001 << next_ph;
                    end else begin
                        timer_d = sat_inc(timer_q);
                    end
                end
            end
            default: begin
                state_d = ST_ALLRED;
                timer_d = '0;
            end
        endcase

        pend_d = (pend_q & ~clr) | set;

        // Lamps are decoded from the next state so they change on the same edge as the state.
        grant_d = 4'b0000;
        m1_d    = LAMP_R;
        m2_d    = LAMP_R;
        mt_d    = LAMP_R;
        s_d     = LAMP_R;
        walk_d  = 1'b0;
        lamp_on = (state_d == ST_GREEN) ? LAMP_G : LAMP_Y;
        if ((state_d == ST_GREEN) || (state_d == ST_YELLOW)) begin
            grant_d = 4'b0001 << cur_d;
            case (cur_d)
                2'd0: begin
                    m1_d = lamp_on;
                    m2_d = lamp_on;
                end
                2'd1:    mt_d   = lamp_on;
                2'd2:    s_d    = lamp_on;
                default: walk_d = (state_d == ST_GREEN);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ALLRED;
            timer_q  <= '0;
            pend_q   <= 4'b0000;
            rr_ptr_q <= 2'd0;
            cur_q    <= 2'd0;
            grant_q  <= 4'b0000;
            m1_q     <= LAMP_R;
            m2_q     <= LAMP_R;
            mt_q     <= LAMP_R;
            s_q      <= LAMP_R;
            walk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            grant_q  <= grant_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
            mt_q     <= mt_d;
            s_q      <= s_d;
            walk_q   <= walk_d;
        end
    end

    assign grant    = grant_q;
    assign light_M1 = m1_q;
    assign light_M2 = m2_q;
    assign light_MT = mt_q;
    assign light_S  = s_q;
    assign walk     = walk_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed junction scenarios followed by random requests/ticks against a phase model.
module tb_traffic_phase_scheduler;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 12;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
`ifdef EMERG_PREEMPT_EN
    localparam bit HAS_EMERG = 1'b1;
`else
    localparam bit HAS_EMERG = 1'b0;
`endif

    // {grant, M1, M2, MT, S, walk}
    localparam logic [16:0] ALL_RED = {4'b0000, 3'b100, 3'b100, 3'b100, 3'b100, 1'b0};
    localparam logic [16:0] M_GREEN = {4'b0001, 3'b001, 3'b001, 3'b100, 3'b100, 1'b0};
    localparam logic [16:0] M_YEL   = {4'b0001, 3'b010, 3'b010, 3'b100, 3'b100, 1'b0};
    localparam logic [16:0] MT_YEL  = {4'b0010, 3'b100, 3'b100, 3'b010, 3'b100, 1'b0};
    localparam logic [16:0] S_GREEN = {4'b0100, 3'b100, 3'b100, 3'b100, 3'b001, 1'b0};
    localparam logic [16:0] S_YEL   = {4'b0100, 3'b100, 3'b100, 3'b100, 3'b010, 1'b0};
    localparam logic [16:0] WALK_ON = {4'b1000, 3'b100, 3'b100, 3'b100, 3'b100, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       emerg = 1'b0;
    logic [3:0] grant;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       walk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: mode 0=green 1=yellow 2=all-red, phase served, ticks spent in mode, pending requests.
    int         m_mode, m_ph, m_el;
    logic [3:0] m_pend;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .req      (req),
`ifdef EMERG_PREEMPT_EN
        .emerg    (emerg),
`endif
        .grant    (grant),
        .light_M1 (light_M1),
        .light_M2 (light_M2),
        .light_MT (light_MT),
        .light_S  (light_S),
        .walk     (walk)
    );

    function automatic logic [16:0] dut_out();
        return {grant, light_M1, light_M2, light_MT, light_S, walk};
    endfunction

    function automatic logic [16:0] exp_out(input int mode, input int ph);
        logic [2:0] lm [4];
        logic [2:0] on;
        logic       w;
        logic [3:0] g;
        for (int i = 0; i < 4; i++) lm[i] = 3'b100;
        w = 1'b0;
        g = 4'b0000;
        if (mode != 2) begin
            g  = 4'b0001 << ph;
            on = (mode == 0) ? 3'b001 : 3'b010;
            if (ph == 0) begin
                lm[0] = on;
                lm[1] = on;
            end else if (ph == 1) begin
                lm[2] = on;
            end else if (ph == 2) begin
                lm[3] = on;
            end else begin
                w = (mode == 0);
            end
        end
        return {g, lm[0], lm[1], lm[2], lm[3], w};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 2;
        m_ph   = 0;
        m_el   = 0;
        m_pend = 4'b0000;
    endtask

    task automatic m_step(input logic t, input logic [3:0] r, input logic e);
        logic [3:0] others;
        logic [3:0] setm;
        logic       leave;
        int         nxt;
        setm  = r;
        leave = 1'b0;
        if (m_mode == 0) begin
            others = m_pend;
            others[m_ph] = 1'b0;
            if (e && m_ph != 0) leave = 1'b1;
            if (t && m_el >= GREEN_MIN - 1 && others != 0 && !(e && m_ph == 0)) leave = 1'b1;
            if (t && m_ph != 0 && m_el == GREEN_MAX - 1) leave = 1'b1;
            if (leave) begin
                m_mode = 1;
                m_el   = 0;
            end else begin
                setm[m_ph] = 1'b0;
                if (t) m_el++;
            end
            m_pend = m_pend | setm;
        end else if (m_mode == 1) begin
            if (t) begin
                if (m_el == YELLOW_T - 1) begin
                    m_mode = 2;
                    m_el   = 0;
                end else m_el++;
            end
            m_pend = m_pend | setm;
        end else begin
            if (t && m_el == ALLRED_T - 1) begin
                nxt = 0;
                if (!e) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (m_pend[(m_ph + k) % 4] && nxt == 0 && ((m_ph + k) % 4) != 0) begin
                            nxt = (m_ph + k) % 4;
                            break;
                        end else if (m_pend[(m_ph + k) % 4]) begin
                            break;
                        end
                    end
                end
                m_ph   = nxt;
                m_mode = 0;
                m_el   = 0;
                m_pend[nxt] = 1'b0;
            end else if (t) begin
                m_el++;
            end
            m_pend = m_pend | setm;
        end
    endtask

    // One clock: drive inputs, let the edge pass, advance the model, compare every lamp.
    task automatic cyc(input logic t, input logic [3:0] r, input logic e);
        tick  = t;
        req   = r;
        emerg = e;
        @(posedge clk);
        #1;
        m_step(t, r, e & HAS_EMERG);
        check("model", dut_out(), exp_out(m_mode, m_ph));
        tick = 1'b0;
        req  = 4'b0000;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("async_reset", dut_out(), ALL_RED);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_until(input string tag, input logic [16:0] target, input int limit, input logic [3:0] r0);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            cyc(1'b1, (i == 0) ? r0 : 4'b0000, emerg);
            if (dut_out() === target) hit = 1'b1;
        end
        n_chk++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL %s observed=timeout required=%h", tag, target);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=no_finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq[$];
        logic [3:0] last;
        logic [3:0] exp_seq [4];
        logic [3:0] r;
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000;
        exp_seq[3] = 4'b0001;

        // Reset state
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_out(), ALL_RED);
        rst_n = 1'b1;

        // Test 1: one all-red tick then main green resting
        cyc(1'b1, 4'b0000, 1'b0);
        check("t1_main_green", dut_out(), M_GREEN);
        repeat (30) cyc(1'b1, 4'b0000, 1'b0);
        check("t1_main_rest", dut_out(), M_GREEN);

        // Test 2: side request at green tick 1 honours GREEN_MIN
        do_reset();
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0100, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
        check("t2_before_min", dut_out(), M_GREEN);
        cyc(1'b1, 4'b0000, 1'b0);
        check("t2_main_yellow", dut_out(), M_YEL);
        cyc(1'b1, 4'b0000, 1'b0);
        check("t2_yellow_hold", dut_out(), M_YEL);
        cyc(1'b1, 4'b0000, 1'b0);
        check("t2_allred", dut_out(), ALL_RED);
        cyc(1'b1, 4'b0000, 1'b0);
        check("t2_side_green", dut_out(), S_GREEN);

        // Test 3: side green capped at GREEN_MAX, then back to main
        repeat (11) cyc(1'b1, 4'b0000, 1'b0);
        check("t3_before_max", dut_out(), S_GREEN);
        cyc(1'b1, 4'b0000, 1'b0);
        check("t3_side_yellow", dut_out(), S_YEL);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
        check("t3_allred", dut_out(), ALL_RED);
        cyc(1'b1, 4'b0000, 1'b0);
        check("t3_back_main", dut_out(), M_GREEN);

        // Test 4: three requests in one cycle served in rotation
        cyc(1'b0, 4'b1110, 1'b0);
        last = 4'b0001;
        for (int i = 0; i < 200 && seq.size() < 4; i++) begin
            cyc(1'b1, 4'b0000, 1'b0);
            if (grant != 4'b0000 && grant != last) begin
                seq.push_back(grant);
                last = grant;
            end
        end
        n_chk++;
        assert (seq.size() == 4) else begin
            n_fail++;
            $error("FAIL t4_order_len observed=%0d required=4", seq.size());
        end
        for (int k = 0; k < seq.size() && k < 4; k++) begin
            check("t4_order", {13'b0, seq[k]}, {13'b0, exp_seq[k]});
        end
        check("t4_main_again", dut_out(), M_GREEN);

        // Test 5: asynchronous reset during main-turn yellow
        run_until("t5_mt_yellow", MT_YEL, 40, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check("t5_async_allred", dut_out(), ALL_RED);
        repeat (2) @(posedge clk);
        #1;
        check("t5_reset_hold", dut_out(), ALL_RED);
        rst_n = 1'b1;
        cyc(1'b1, 4'b0000, 1'b0);
        check("t5_main_after", dut_out(), M_GREEN);

`ifdef EMERG_PREEMPT_EN
        // Test 6: emergency preemption of side green
        run_until("t6_side_green", S_GREEN, 40, 4'b0100);
        cyc(1'b1, 4'b1000, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1);
        check("t6_side_yellow_now", dut_out(), S_YEL);
        repeat (3) cyc(1'b1, 4'b0000, 1'b1);
        check("t6_main_green", dut_out(), M_GREEN);
        repeat (10) cyc(1'b1, 4'b0000, 1'b1);
        check("t6_main_held", dut_out(), M_GREEN);
        emerg = 1'b0;
        run_until("t6_walk_served", WALK_ON, 20, 4'b0000);
`endif

        // Random requests, ticks, preemption and resets against the model
        for (int i = 0; i < 3000; i++) begin
            r = 4'b0000;
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) == 0);
            if (HAS_EMERG && $urandom_range(0, 59) == 0) emerg = ~emerg;
            if ($urandom_range(0, 399) == 0) do_reset();
            cyc(1'($urandom_range(0, 1)), r, emerg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
